// File: rtl/bram_rd_pkg.sv
// Shared defaults and types for the BRAM channel read-back path.
package bram_rd_pkg;

    localparam int unsigned NUM_CH_DEF   = 8;
    localparam int unsigned ADDR_W_DEF   = 18;
    localparam int unsigned DATA_W_DEF   = 8;
    localparam int unsigned LEN_W_DEF    = 16;
    localparam int unsigned BRAM_LAT_DEF = 1;
    localparam int unsigned LANE_W_DEF   = $clog2(NUM_CH_DEF);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } state_e;

endpackage

// File: rtl/bram_rd_issue.sv
// Read issue engine: walks lane-major over (k, c), drives the BRAM read port
// and tags each read so the returning data can be routed to its lane slot.
module bram_rd_issue
    import bram_rd_pkg::*;
#(
    parameter int unsigned NUM_CH   = NUM_CH_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned LEN_W    = LEN_W_DEF,
    parameter int unsigned BRAM_LAT = BRAM_LAT_DEF,
    parameter int unsigned LANE_W   = LANE_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     active,
    input  logic                     stall,
    input  logic [NUM_CH*ADDR_W-1:0] base_i,
    input  logic [LEN_W-1:0]         len_i,
    output logic                     last_issue_o,
    output logic                     bram_en_o,
    output logic [ADDR_W-1:0]        bram_addr_o,
    output logic                     cap_valid_o,
    output logic [LANE_W-1:0]        cap_lane_o
);

    logic [ADDR_W-1:0] base_q [NUM_CH];
    logic [ADDR_W-1:0] base_d [NUM_CH];
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [LEN_W-1:0]  k_q, k_d;
    logic              en_q, en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              tag_vld_q  [BRAM_LAT+1];
    logic              tag_vld_d  [BRAM_LAT+1];
    logic [LANE_W-1:0] tag_lane_q [BRAM_LAT+1];
    logic [LANE_W-1:0] tag_lane_d [BRAM_LAT+1];

    logic [LANE_W-1:0] lane_cur;
    logic [LEN_W-1:0]  k_cur;
    logic              do_issue;
    logic              lane_end;

    // Next read selection. The accepting start cycle already issues lane 0,
    // so the "current" base/length come straight from the inputs on load.
    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            base_d[c] = load ? base_i[c*ADDR_W +: ADDR_W] : base_q[c];
        end
        len_d    = load ? len_i : len_q;
        lane_cur = load ? '0 : lane_q;
        k_cur    = load ? '0 : k_q;

        // Backpressure only holds off the start of a new vector.
        do_issue = load || (active && !(stall && (lane_q == '0)));
        lane_end = (lane_cur == LANE_W'(NUM_CH - 1));
        last_issue_o = do_issue && lane_end && (k_cur == len_d - LEN_W'(1));

        lane_d = lane_q;
        k_d    = k_q;
        en_d   = do_issue;
        addr_d = addr_q;
        if (do_issue) begin
            addr_d = base_d[lane_cur] + ADDR_W'(k_cur);
            lane_d = lane_end ? '0 : lane_cur + LANE_W'(1);
            k_d    = lane_end ? k_cur + LEN_W'(1) : k_cur;
        end

        tag_vld_d[0]  = do_issue;
        tag_lane_d[0] = lane_cur;
        for (int unsigned i = 1; i <= BRAM_LAT; i++) begin
            tag_vld_d[i]  = tag_vld_q[i-1];
            tag_lane_d[i] = tag_lane_q[i-1];
        end
    end

    // Counters, port registers and read-tag delay line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                base_q[c] <= '0;
            end
            len_q  <= '0;
            lane_q <= '0;
            k_q    <= '0;
            en_q   <= 1'b0;
            addr_q <= '0;
            for (int unsigned i = 0; i <= BRAM_LAT; i++) begin
                tag_vld_q[i]  <= 1'b0;
                tag_lane_q[i] <= '0;
            end
        end else begin
            base_q     <= base_d;
            len_q      <= len_d;
            lane_q     <= lane_d;
            k_q        <= k_d;
            en_q       <= en_d;
            addr_q     <= addr_d;
            tag_vld_q  <= tag_vld_d;
            tag_lane_q <= tag_lane_d;
        end
    end

    assign bram_en_o   = en_q;
    assign bram_addr_o = addr_q;
    assign cap_valid_o = tag_vld_q[BRAM_LAT];
    assign cap_lane_o  = tag_lane_q[BRAM_LAT];

endmodule

// File: rtl/bram_channel_reader.sv
// Reads NUM_CH channel regions back from BRAM and streams one assembled
// NUM_CH-lane vector per word index over a valid/ready interface.
module bram_channel_reader
    import bram_rd_pkg::*;
#(
    parameter int unsigned NUM_CH   = NUM_CH_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned LEN_W    = LEN_W_DEF,
    parameter int unsigned BRAM_LAT = BRAM_LAT_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [NUM_CH*ADDR_W-1:0] starting_addr,
    input  logic [LEN_W-1:0]         length,
    output logic                     busy,
    output logic                     done,
    output logic                     bram_en_o,
    output logic [ADDR_W-1:0]        bram_addr_o,
    input  logic [DATA_W-1:0]        bram_rdata_i,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last
);

    localparam int unsigned LANE_W = $clog2(NUM_CH);

    state_e                   state_q, state_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic [LEN_W-1:0]         vec_cnt_q, vec_cnt_d;
    logic [DATA_W-1:0]        asm_q [NUM_CH];
    logic [DATA_W-1:0]        asm_d [NUM_CH];
    logic                     asm_full_q, asm_full_d;
    logic [NUM_CH*DATA_W-1:0] out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;

    logic              load;
    logic              stall;
    logic              last_issue;
    logic              cap_valid;
    logic [LANE_W-1:0] cap_lane;
    logic              handshake;
    logic              out_free;
    logic              asm_complete;
    logic              xfer;

    assign load      = (state_q == IDLE) && start && (length != '0);
    assign handshake = out_valid_q && out_ready;
    assign out_free  = !out_valid_q || out_ready;
    // Hold off the next vector unless the one in flight is sure to find the
    // output register free when it completes; otherwise its in-flight
    // successor lanes would overwrite a finished, untransferred vector.
    assign stall     = asm_full_q || !out_free;

    bram_rd_issue #(
        .NUM_CH   (NUM_CH),
        .ADDR_W   (ADDR_W),
        .LEN_W    (LEN_W),
        .BRAM_LAT (BRAM_LAT),
        .LANE_W   (LANE_W)
    ) u_issue (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .active       (state_q == ISSUE),
        .stall        (stall),
        .base_i       (starting_addr),
        .len_i        (length),
        .last_issue_o (last_issue),
        .bram_en_o    (bram_en_o),
        .bram_addr_o  (bram_addr_o),
        .cap_valid_o  (cap_valid),
        .cap_lane_o   (cap_lane)
    );

    // Pass sequencing: issue, drain the last vector, pulse done.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d = length;
                    if (length == '0) begin
                        state_d = FINISH;
                    end else if (last_issue) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (last_issue) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (handshake && out_last_q) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Lane capture into the assembly register and hand-off to the output.
    always_comb begin
        asm_d = asm_q;
        if (cap_valid) begin
            asm_d[cap_lane] = bram_rdata_i;
        end
        asm_complete = asm_full_q || (cap_valid && (cap_lane == LANE_W'(NUM_CH - 1)));
        xfer         = asm_complete && out_free;
        asm_full_d   = asm_complete && !xfer;

        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        out_last_d  = out_last_q && !handshake;
        vec_cnt_d   = load ? '0 : vec_cnt_q;
        if (xfer) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                out_data_d[c*DATA_W +: DATA_W] = asm_d[c];
            end
            out_valid_d = 1'b1;
            out_last_d  = (vec_cnt_q == len_q - LEN_W'(1));
            vec_cnt_d   = vec_cnt_q + LEN_W'(1);
        end
    end

    // State, assembly and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            vec_cnt_q   <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                asm_q[c] <= '0;
            end
            asm_full_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            vec_cnt_q   <= vec_cnt_d;
            asm_q       <= asm_d;
            asm_full_q  <= asm_full_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign busy      = (state_q == ISSUE) || (state_q == DRAIN);
    assign done      = (state_q == FINISH);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_bram_channel_reader.sv
// Directed bench for bram_channel_reader with a queue-based reference model.
module tb_bram_channel_reader;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [143:0] starting_addr;
    logic [15:0]  length;
    logic         busy;
    logic         done;
    logic         bram_en_o;
    logic [17:0]  bram_addr_o;
    logic [7:0]   bram_rdata_i;
    logic [63:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;

    bram_channel_reader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .starting_addr (starting_addr),
        .length        (length),
        .busy          (busy),
        .done          (done),
        .bram_en_o     (bram_en_o),
        .bram_addr_o   (bram_addr_o),
        .bram_rdata_i  (bram_rdata_i),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM with one cycle of read latency; mem[a] = a[7:0].
    always @(posedge clk) begin
        if (bram_en_o) bram_rdata_i <= bram_addr_o[7:0];
    end

    int total = 0;
    int bad   = 0;

    logic [17:0] rd_q [$];
    logic [63:0] exp_q [$];
    logic        exp_l [$];
    logic [17:0] base_m [8];
    logic [63:0] rx [16];
    int          n_rx = 0;
    int          done_cnt = 0;
    logic        chk_en = 1'b0;
    logic        zero_len = 1'b0;
    logic        pending_done = 1'b0;
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [63:0] prev_d = '0;
    logic        prev_l = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison of the read port and the output stream.
    always @(negedge clk) begin
        logic [63:0] ev;
        logic        el;
        if (!chk_en) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_data", out_data, prev_d);
                check("hold_last", 64'(out_last), 64'(prev_l));
            end
            if (bram_en_o) begin
                if (rd_q.size() == 0) check("extra_read", 64'(bram_en_o), 64'(0));
                else check("rd_addr", 64'(bram_addr_o), 64'(rd_q.pop_front()));
            end
            if (pending_done) begin
                check("done_after_last", 64'(done), 64'(1));
                pending_done = 1'b0;
            end else if (done && !zero_len) begin
                check("spurious_done", 64'(done), 64'(0));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_vector", 64'(out_valid), 64'(0));
                end else begin
                    ev = exp_q.pop_front();
                    el = exp_l.pop_front();
                    check("vec_data", out_data, ev);
                    check("vec_last", 64'(out_last), 64'(el));
                    if (n_rx < 16) rx[n_rx] = out_data;
                    n_rx++;
                    if (out_last) pending_done = 1'b1;
                end
            end
            if (done) done_cnt++;
            prev_v = out_valid;
            prev_r = out_ready;
            prev_d = out_data;
            prev_l = out_last;
        end
    end

    // Builds the expected read order and vectors, then pulses start.
    task automatic start_pass(input int len);
        logic [17:0] a;
        logic [63:0] v;
        for (int k = 0; k < len; k++) begin
            v = '0;
            for (int c = 0; c < 8; c++) begin
                a = 18'(base_m[c] + 18'(k));
                rd_q.push_back(a);
                v[c*8 +: 8] = a[7:0];
            end
            exp_q.push_back(v);
            exp_l.push_back(k == len - 1);
        end
        for (int c = 0; c < 8; c++) starting_addr[c*18 +: 18] = base_m[c];
        length = 16'(len);
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int n;
        n = 0;
        while (!done && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_seen", 64'(done), 64'(1));
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string p);
        check({p, "_busy"}, 64'(busy), 64'(0));
        check({p, "_done"}, 64'(done), 64'(0));
        check({p, "_en"}, 64'(bram_en_o), 64'(0));
        check({p, "_addr"}, 64'(bram_addr_o), 64'(0));
        check({p, "_data"}, out_data, 64'(0));
        check({p, "_valid"}, 64'(out_valid), 64'(0));
        check({p, "_last"}, 64'(out_last), 64'(0));
    endtask

    task automatic default_bases();
        for (int c = 0; c < 8; c++) base_m[c] = 18'(1000 * c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        starting_addr = '0;
        length = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Test 1: basic pass, latency and last/done timing.
        default_bases();
        n_rx = 0;
        done_cnt = 0;
        start_pass(4);
        check("pin_v0_lane1", 64'(exp_q[0][15:8]), 64'(8'hE8));
        check("pin_v3_lane7", 64'(exp_q[3][63:56]), 64'(8'h5B));
        check("pin_v3_last", 64'(exp_l[3]), 64'(1));
        check("t1_busy", 64'(busy), 64'(1));
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid && first == 0) first = i;
        end
        check("t1_first_valid_edge", 64'(first), 64'(9));
        wait_done(100);
        check("t1_vectors", 64'(n_rx), 64'(4));
        check("t1_done_cnt", 64'(done_cnt), 64'(1));
        check("t1_busy_end", 64'(busy), 64'(0));

        // Test 2: backpressure while vector 1 is presented.
        n_rx = 0;
        start_pass(4);
        n = 0;
        while (!(out_valid && n_rx == 1) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("t2_v1_valid", 64'(out_valid), 64'(1));
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i >= 10) check("t2_en_stalled", 64'(bram_en_o), 64'(0));
        end
        check("t2_v2_read", 64'(rd_q.size() <= 8), 64'(1));
        out_ready = 1'b1;
        wait_done(100);
        check("t2_vectors", 64'(n_rx), 64'(4));

        // Test 3: zero length.
        zero_len = 1'b1;
        start_pass(0);
        check("t3_done", 64'(done), 64'(1));
        check("t3_busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        check("t3_done_clr", 64'(done), 64'(0));
        check("t3_busy_clr", 64'(busy), 64'(0));
        zero_len = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Test 4: address wrap on channel 0.
        default_bases();
        base_m[0] = 18'd262142;
        n_rx = 0;
        start_pass(4);
        wait_done(100);
        check("t4_lane0_k0", 64'(rx[0][7:0]), 64'(8'hFE));
        check("t4_lane0_k1", 64'(rx[1][7:0]), 64'(8'hFF));
        check("t4_lane0_k2", 64'(rx[2][7:0]), 64'(8'h00));
        check("t4_lane0_k3", 64'(rx[3][7:0]), 64'(8'h01));

        // Test 6: start during a pass is ignored.
        default_bases();
        n_rx = 0;
        done_cnt = 0;
        start_pass(4);
        repeat (12) @(posedge clk);
        #1;
        for (int c = 0; c < 8; c++) starting_addr[c*18 +: 18] = 18'(50000 + 7 * c);
        length = 16'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(100);
        repeat (5) @(posedge clk);
        #1;
        check("t6_vectors", 64'(n_rx), 64'(4));
        check("t6_done_cnt", 64'(done_cnt), 64'(1));

        // Test 5: reset while vector 2 assembles, then a fresh pass.
        default_bases();
        n_rx = 0;
        start_pass(4);
        n = 0;
        while (n_rx < 2 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_two_received", 64'(n_rx), 64'(2));
        chk_en = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_zero("t5_rst");
        rd_q.delete();
        exp_q.delete();
        exp_l.delete();
        pending_done = 1'b0;
        chk_en = 1'b1;
        n_rx = 0;
        done_cnt = 0;
        start_pass(4);
        wait_done(100);
        check("t5_vectors", 64'(n_rx), 64'(4));
        check("t5_done_cnt", 64'(done_cnt), 64'(1));
        check("t5_lane7_k0", 64'(rx[0][63:56]), 64'(8'h58));

        check("model_rd_empty", 64'(rd_q.size()), 64'(0));
        check("model_vec_empty", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
